// File: rtl/inference_controller.sv
// Sequences one MNIST inference per debounced key press: snapshot pixels, pulse start, wait for done/timeout.
// Optional build macro AUTO_INFER_EN: also starts a run when the drawing grid has been stable and differs from the last snapshot.
module inference_controller #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned TIMEOUT_CYCLES  = 4096,
  parameter int unsigned N_PIX           = 784
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             key_start_n,
  input  logic [N_PIX-1:0] pixel_live,
  input  logic             nn_done,
  input  logic [3:0]       nn_argmax,
  output logic             nn_start,
  output logic [N_PIX-1:0] nn_pixels,
  output logic [3:0]       result,
  output logic             result_valid,
  output logic             timeout_err,
  output logic             busy,
  output logic [2:0]       state_dbg
);

  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CAPTURE = 3'd1,
    ST_START   = 3'd2,
    ST_WAIT    = 3'd3,
    ST_RELEASE = 3'd4
  } state_t;

  state_t          state;
  logic            key_sync1;
  logic            key_sync2;
  logic            key_db;
  logic            press;
  logic            trigger;
  logic [DB_W-1:0] db_cnt;
  logic [TO_W-1:0] wait_cnt;

  // Key synchroniser and debouncer; press is a one-cycle pulse on the released->pressed flip
  always_ff @(posedge clk) begin
    if (!resetn) begin
      key_sync1 <= 1'b1;
      key_sync2 <= 1'b1;
      key_db    <= 1'b1;
      db_cnt    <= '0;
      press     <= 1'b0;
    end else begin
      key_sync1 <= key_start_n;
      key_sync2 <= key_sync1;
      press     <= 1'b0;
      if (key_sync2 == key_db) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        key_db <= key_sync2;
        db_cnt <= '0;
        press  <= key_db & ~key_sync2;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

`ifdef AUTO_INFER_EN
  logic [N_PIX-1:0] pixel_prev;
  logic [DB_W-1:0]  stab_cnt;
  logic             auto_trig;

  // Stability tracker: counts consecutive cycles with an unchanged drawing grid
  always_ff @(posedge clk) begin
    if (!resetn) begin
      pixel_prev <= '0;
      stab_cnt   <= '0;
    end else begin
      pixel_prev <= pixel_live;
      if (pixel_live != pixel_prev) begin
        stab_cnt <= '0;
      end else if (stab_cnt != DB_W'(DEBOUNCE_CYCLES)) begin
        stab_cnt <= stab_cnt + 1'b1;
      end
    end
  end

  assign auto_trig = (pixel_live == pixel_prev) &&
                     (stab_cnt >= DB_W'(DEBOUNCE_CYCLES - 1)) &&
                     (pixel_live != nn_pixels);
  assign trigger   = press | auto_trig;
`else
  assign trigger = press;
`endif

  // Run sequencer
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state        <= ST_IDLE;
      nn_pixels    <= '0;
      result       <= 4'hF;
      result_valid <= 1'b0;
      timeout_err  <= 1'b0;
      wait_cnt     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (trigger) begin
            state        <= ST_CAPTURE;
            result_valid <= 1'b0;
            timeout_err  <= 1'b0;
          end
        end
        ST_CAPTURE: begin
          nn_pixels <= pixel_live;
          state     <= ST_START;
        end
        ST_START: begin
          wait_cnt <= '0;
          state    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (wait_cnt != TO_W'(TIMEOUT_CYCLES - 1)) begin
            wait_cnt <= wait_cnt + 1'b1;
          end
          // done has priority over a timeout landing on the same cycle
          if (nn_done) begin
            if (nn_argmax <= 4'd9) begin
              result       <= nn_argmax;
              result_valid <= 1'b1;
            end else begin
              result       <= 4'hF;
              result_valid <= 1'b0;
            end
            state <= ST_RELEASE;
          end else if (wait_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
            timeout_err  <= 1'b1;
            result       <= 4'hF;
            result_valid <= 1'b0;
            state        <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (!nn_done && key_db) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign nn_start  = (state == ST_START);
  assign busy      = (state != ST_IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_inference_controller.sv
// Self-checking bench for inference_controller: vector table, hand-written corner sequences, randomized runs.
module tb_inference_controller;

  localparam int unsigned DB = 4;
  localparam int unsigned TO = 32;
  localparam int unsigned NP = 784;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          key_start_n = 1'b1;
  logic [NP-1:0] pixel_live = '0;
  logic          nn_done = 1'b0;
  logic [3:0]    nn_argmax = 4'd0;
  logic          nn_start;
  logic [NP-1:0] nn_pixels;
  logic [3:0]    result;
  logic          result_valid;
  logic          timeout_err;
  logic          busy;
  logic [2:0]    state_dbg;

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;

  inference_controller #(
    .DEBOUNCE_CYCLES(DB),
    .TIMEOUT_CYCLES (TO),
    .N_PIX          (NP)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .key_start_n (key_start_n),
    .pixel_live  (pixel_live),
    .nn_done     (nn_done),
    .nn_argmax   (nn_argmax),
    .nn_start    (nn_start),
    .nn_pixels   (nn_pixels),
    .result      (result),
    .result_valid(result_valid),
    .timeout_err (timeout_err),
    .busy        (busy),
    .state_dbg   (state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    int    d;
    int    am;
    int    er;
    int    ev;
    int    et;
  } vec_t;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // One clock; sample 1ns after the rising edge and count cycles with start high
  task automatic step();
    @(posedge clk);
    #1;
    if (nn_start) start_cnt++;
  endtask

  // Outcome of a run whose done arrives on WAIT cycle d (first WAIT cycle is 0)
  function automatic void expect_outcome(input int d, input int am,
                                         output int r, output int v, output int t);
    if (d <= int'(TO) - 1) begin
      t = 0;
      if (am <= 9) begin r = am; v = 1; end
      else begin r = 15; v = 0; end
    end else begin
      r = 15; v = 0; t = 1;
    end
  endfunction

  function automatic logic [NP-1:0] rand_pix();
    logic [NP-1:0] p;
    for (int i = 0; i < int'(NP); i++) p[i] = 1'($urandom_range(0, 1));
    return p;
  endfunction

  task automatic do_reset();
    resetn = 1'b0;
    key_start_n = 1'b1;
    nn_done = 1'b0;
    step();
    step();
    resetn = 1'b1;
  endtask

  task automatic run(input string name, input logic [NP-1:0] pix, input int d, input int am,
                     input bit bounce, input int er, input int ev, input int et);
    int  n;
    bit  seen;
    start_cnt = 0;
    pixel_live = pix;
    if (bounce) begin
      key_start_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
        key_start_n = ~key_start_n;
        step();
        step();
      end
    end
    key_start_n = 1'b0;
    seen = 1'b0;
    for (n = 0; n < 60 && !seen; n++) begin
      step();
      if (nn_start) seen = 1'b1;
    end
    chk({name, " start_seen"}, int'(seen), 1);
    if (!seen) begin
      do_reset();
      return;
    end
    // 2 sync + DB debounce samples + press reg + CAPTURE -> START
    if (!bounce) chk({name, " start_latency"}, n, 8);
    chk({name, " cleared_timeout_at_start"}, int'(timeout_err), 0);
    chk({name, " cleared_valid_at_start"}, int'(result_valid), 0);
    pixel_live = ~pix;
    step();
    chk({name, " in_wait"}, int'(state_dbg), 3);
    chk({name, " busy_wait"}, int'(busy), 1);
    repeat ((d < int'(TO)) ? d : int'(TO) - 1) step();
    if (d < int'(TO)) begin
      nn_done = 1'b1;
      nn_argmax = 4'(am);
    end
    step();
    chk({name, " in_release"}, int'(state_dbg), 4);
    chk({name, " result"}, int'(result), er);
    chk({name, " result_valid"}, int'(result_valid), ev);
    chk({name, " timeout_err"}, int'(timeout_err), et);
    chk({name, " snapshot_held"}, int'(nn_pixels == pix), 1);
    repeat (3) step();
    chk({name, " release_hold"}, int'(state_dbg), 4);
    nn_done = 1'b0;
    key_start_n = 1'b1;
    seen = 1'b0;
    for (n = 0; n < 40 && !seen; n++) begin
      step();
      if (state_dbg == 3'd0) seen = 1'b1;
    end
    chk({name, " back_to_idle"}, int'(seen), 1);
    chk({name, " single_start_cycle"}, start_cnt, 1);
    chk({name, " result_retained"}, int'(result), er);
  endtask

  vec_t vecs[7];

  initial begin
    int r, v, t, d, am;
    bit seen;
    logic [NP-1:0] pa;

    vecs[0] = '{"normal_7",      10,  7,  7, 1, 0};
    vecs[1] = '{"digit_0",        0,  0,  0, 1, 0};
    vecs[2] = '{"digit_9",        5,  9,  9, 1, 0};
    vecs[3] = '{"bad_argmax_12",  3, 12, 15, 0, 0};
    vecs[4] = '{"done_on_to_cyc",31,  4,  4, 1, 0};
    vecs[5] = '{"timeout",       40,  2, 15, 0, 1};
    vecs[6] = '{"bad_argmax_10",  2, 10, 15, 0, 0};

    // Reset values
    resetn = 1'b0;
    step();
    step();
    chk("reset result", int'(result), 15);
    chk("reset result_valid", int'(result_valid), 0);
    chk("reset nn_start", int'(nn_start), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset state_dbg", int'(state_dbg), 0);
    chk("reset timeout_err", int'(timeout_err), 0);
    chk("reset nn_pixels_zero", int'(nn_pixels == '0), 1);
    resetn = 1'b1;
    repeat (3) step();
    chk("idle_no_spurious_start", start_cnt, 0);

    for (int i = 0; i < 7; i++)
      run(vecs[i].name, rand_pix(), vecs[i].d, vecs[i].am, 1'b0,
          vecs[i].er, vecs[i].ev, vecs[i].et);

    // Bouncing key must still yield exactly one start pulse
    run("bounce", rand_pix(), 6, 3, 1'b1, 3, 1, 0);

    // Reset in the middle of WAIT aborts immediately
    pa = rand_pix();
    pixel_live = pa;
    key_start_n = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 60 && !seen; n++) begin
      step();
      if (nn_start) seen = 1'b1;
    end
    chk("midreset start_seen", int'(seen), 1);
    step();
    step();
    chk("midreset in_wait", int'(state_dbg), 3);
    resetn = 1'b0;
    key_start_n = 1'b1;
    step();
    chk("midreset state_dbg", int'(state_dbg), 0);
    chk("midreset busy", int'(busy), 0);
    chk("midreset result", int'(result), 15);
    chk("midreset nn_start", int'(nn_start), 0);
    chk("midreset nn_pixels_zero", int'(nn_pixels == '0), 1);
    resetn = 1'b1;
    repeat (12) step();
    chk("midreset stays_idle", int'(state_dbg), 0);

    // Randomized runs against the outcome model
    for (int i = 0; i < 10; i++) begin
      d  = int'($urandom_range(0, 40));
      am = int'($urandom_range(0, 15));
      expect_outcome(d, am, r, v, t);
      run($sformatf("rand%0d_d%0d_a%0d", i, d, am), rand_pix(), d, am,
          1'($urandom_range(0, 1)), r, v, t);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
